div_period_meter: RTL
=====================

Name: div_period_meter

Overview:
Downstream checker for the even clock divider. Samples the divided clock as data in the fast clk domain and measures period and high time over a programmable number of periods. Compares the results against the requested divide factor N and reports sticky period, duty and timeout errors. Used in bring-up and self-test to confirm the divider output before it is distributed.

Parameters:
WIDTH, 8, width of divide factor N (matches divider)
CNT_W, 16, width of period/high/timeout counters
NUM_PERIODS, 4, rising-edge-to-rising-edge periods measured per run (>=1)
TIMEOUT, 1024, clk cycles without a rising edge before abort (< 2**CNT_W)

Ports:
clk  in  1  fast reference clock (same clock that drives the divider)
reset_n  in  1  asynchronous, active-low reset
div_in  in  1  divided clock under test, treated as data
n_exp  in  WIDTH  expected divide factor; latched at start
start  in  1  single-cycle request to begin a measurement
busy  out  1  high from accepted start until done
done  out  1  single-cycle pulse when a run ends
last_period  out  CNT_W  clk cycles in most recent complete period
last_high  out  CNT_W  clk cycles div_in sampled high in that period
err_period  out  1  sticky: some period != latched N
err_duty  out  1  sticky: some high time != N>>1
timeout  out  1  sticky: no rising edge within TIMEOUT cycles
cfg_err  out  1  start seen with n_exp==0 or n_exp odd

Behaviour:
- Reset value of every output is 0. Reset clears the FSM to IDLE, all counters, the latched N and the edge history. Reset asserted mid-run aborts the run with no done pulse.
- Sampling: s = div_in registered once, p = s delayed one cycle. rise = s & ~p. All measurements are in clk cycles on the sampled signal.
- FSM states are IDLE, ARM, MEASURE, DONE.
- IDLE:
  - start with n_exp even and nonzero latches n_exp. It clears last_period, last_high, err_period, err_duty, timeout and cfg_err, then moves to ARM. busy=1 from the next cycle.
  - start with n_exp==0 or odd sets cfg_err=1 and stays in IDLE; busy stays 0 and no done pulse is issued. cfg_err clears on the next accepted start.
- ARM:
  - Waits for the first rise, which is the reference edge. The timeout counter increments each cycle.
  - On rise, go to MEASURE with period counter=1, high counter=1, timeout counter=0.
  - If the timeout counter reaches TIMEOUT-1 without a rise, set timeout=1 and go to DONE.
- MEASURE:
  - Each cycle without rise: period counter +1; high counter +1 when s==1; timeout counter +1.
  - On rise: last_period <= period counter; last_high <= high counter.
  - On the same rise: set err_period if period counter != N; set err_duty if high counter != N>>1.
  - On the same rise: periods_done +1 and counters reload as in ARM.
  - When periods_done reaches NUM_PERIODS, go to DONE on that same rise.
  - Timeout rule is the same as in ARM.
  - Rise and timeout in the same cycle: the rise wins and the timeout counter reloads.
- Counters saturate at all-ones and do not wrap. A saturated period counter always mismatches and sets err_period.
- DONE: done=1 for exactly one cycle, busy drops to 0 in the same cycle, then return to IDLE. Results hold until the next accepted start.
- start while busy or in DONE is ignored and has no effect on results.
- n_exp changes after start are ignored; the latched value is used.
- Latency: done asserts the cycle after the NUM_PERIODS-th rise is detected, which is 2 cycles after the div_in rising transition without sync.

Optional Feature:
DIV_METER_SYNC_EN. When defined, div_in passes through a 2-flop synchronizer before the sampling register. Measurements are unchanged, but done latency grows by 2 cycles, so the meter can check a divider clocked asynchronously. When undefined, only the single sampling register is present.

Test Plan:
- n_exp=4, div_in toggling every 2 clk, NUM_PERIODS=4, start -> after 4 periods: last_period=4, last_high=2, no errors, one done pulse, busy high throughout the run.
- n_exp=6, div_in period 8 with high 4 -> err_period=1, err_duty=1, last_period=8, last_high=4, done still issued after 4 periods.
- n_exp=8, div_in held 0 (divider disabled) -> timeout=1 and done exactly TIMEOUT cycles after entering ARM; last_period=0.
- start with n_exp=0, then with n_exp=5 -> cfg_err=1 each time, busy stays 0, no done; a following start with n_exp=4 clears cfg_err.
- Reset_n pulsed low during MEASURE, then released -> all outputs 0 and state IDLE; no done pulse. A fresh start measures correctly.
- start pulses during busy -> ignored; results match a single-start run.

Source files
------------

// File: rtl/div_period_meter_if.sv
// div_period_meter_if: control, result and sampled-clock bundle between a divider test controller and div_period_meter.
interface div_period_meter_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             div_in;
    logic [WIDTH-1:0] n_exp;
    logic             start;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] last_period;
    logic [CNT_W-1:0] last_high;
    logic             err_period;
    logic             err_duty;
    logic             timeout;
    logic             cfg_err;
    modport master (
        output div_in, n_exp, start,
        input  busy, done, last_period, last_high, err_period, err_duty, timeout, cfg_err
    );
    modport slave (
        input  div_in, n_exp, start,
        output busy, done, last_period, last_high, err_period, err_duty, timeout, cfg_err
    );
endinterface

// File: rtl/div_period_meter.sv
// div_period_meter: measures period and high time of a divided clock sampled in the clk domain.
// Define DIV_METER_SYNC_EN to put a 2-flop synchronizer ahead of the sampling register.
module div_period_meter #(
    parameter int WIDTH       = 8,
    parameter int CNT_W       = 16,
    parameter int NUM_PERIODS = 4,
    parameter int TIMEOUT     = 1024
) (
    input logic clk,
    input logic reset_n,
    div_period_meter_if.slave m
);
    localparam int PD_W = $clog2(NUM_PERIODS + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [PD_W-1:0] PD_LAST = PD_W'(NUM_PERIODS - 1);
    typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic             s_q, s_d, p_q, p_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d, hcnt_q, hcnt_d, tcnt_q, tcnt_d;
    logic [PD_W-1:0]  pd_q, pd_d;
    logic [CNT_W-1:0] last_period_q, last_period_d, last_high_q, last_high_d;
    logic             err_period_q, err_period_d, err_duty_q, err_duty_d;
    logic             timeout_q, timeout_d, cfg_err_q, cfg_err_d;
    logic             rise, n_ok, p_bad, h_bad;
    logic [CNT_W-1:0] pcnt_inc, hcnt_inc, tcnt_inc;
`ifdef DIV_METER_SYNC_EN
    logic sync1_q, sync2_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= m.div_in;
            sync2_q <= sync1_q;
        end
    end
    assign s_d = sync2_q;
`else
    assign s_d = m.div_in;
`endif
    assign p_d      = s_q;
    assign rise     = s_q & ~p_q;
    assign n_ok     = (m.n_exp != '0) && !m.n_exp[0];
    assign pcnt_inc = (&pcnt_q) ? pcnt_q : pcnt_q + CNT_W'(1);
    assign hcnt_inc = (&hcnt_q) ? hcnt_q : hcnt_q + CNT_W'(1);
    assign tcnt_inc = (&tcnt_q) ? tcnt_q : tcnt_q + CNT_W'(1);
    // a saturated period count can never be a valid measurement
    assign p_bad    = (pcnt_q != CNT_W'(n_q)) || (&pcnt_q);
    assign h_bad    = hcnt_q != CNT_W'(n_q >> 1);
    always_comb begin
        state_d       = state_q;
        n_d           = n_q;
        pcnt_d        = pcnt_q;
        hcnt_d        = hcnt_q;
        tcnt_d        = tcnt_q;
        pd_d          = pd_q;
        last_period_d = last_period_q;
        last_high_d   = last_high_q;
        err_period_d  = err_period_q;
        err_duty_d    = err_duty_q;
        timeout_d     = timeout_q;
        cfg_err_d     = cfg_err_q;
        case (state_q)
            IDLE: begin
                if (m.start && n_ok) begin
                    state_d       = ARM;
                    n_d           = m.n_exp;
                    tcnt_d        = '0;
                    pd_d          = '0;
                    last_period_d = '0;
                    last_high_d   = '0;
                    err_period_d  = 1'b0;
                    err_duty_d    = 1'b0;
                    timeout_d     = 1'b0;
                    cfg_err_d     = 1'b0;
                end else if (m.start) begin
                    cfg_err_d = 1'b1;
                end
            end
            ARM, MEASURE: begin
                pcnt_d = pcnt_inc;
                hcnt_d = s_q ? hcnt_inc : hcnt_q;
                tcnt_d = tcnt_inc;
                if (rise) begin
                    pcnt_d = CNT_W'(1);
                    hcnt_d = CNT_W'(1);
                    tcnt_d = '0;
                    if (state_q == ARM) begin
                        state_d = MEASURE;
                    end else begin
                        last_period_d = pcnt_q;
                        last_high_d   = hcnt_q;
                        err_period_d  = err_period_q | p_bad;
                        err_duty_d    = err_duty_q | h_bad;
                        pd_d          = pd_q + PD_W'(1);
                        state_d       = (pd_q == PD_LAST) ? DONE : MEASURE;
                    end
                end else if (tcnt_q == TO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            n_q           <= '0;
            s_q           <= 1'b0;
            p_q           <= 1'b0;
            pcnt_q        <= '0;
            hcnt_q        <= '0;
            tcnt_q        <= '0;
            pd_q          <= '0;
            last_period_q <= '0;
            last_high_q   <= '0;
            err_period_q  <= 1'b0;
            err_duty_q    <= 1'b0;
            timeout_q     <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            n_q           <= n_d;
            s_q           <= s_d;
            p_q           <= p_d;
            pcnt_q        <= pcnt_d;
            hcnt_q        <= hcnt_d;
            tcnt_q        <= tcnt_d;
            pd_q          <= pd_d;
            last_period_q <= last_period_d;
            last_high_q   <= last_high_d;
            err_period_q  <= err_period_d;
            err_duty_q    <= err_duty_d;
            timeout_q     <= timeout_d;
            cfg_err_q     <= cfg_err_d;
        end
    end
    assign m.busy        = (state_q == ARM) || (state_q == MEASURE);
    assign m.done        = state_q == DONE;
    assign m.last_period = last_period_q;
    assign m.last_high   = last_high_q;
    assign m.err_period  = err_period_q;
    assign m.err_duty    = err_duty_q;
    assign m.timeout     = timeout_q;
    assign m.cfg_err     = cfg_err_q;
endmodule
